// File: rtl/ro_pair_compare.sv
// PUF ring-oscillator pair measurement: gates both ROs, counts synchronized rising
// edges over a fixed window, then compares the counts into one response bit.
module ro_pair_compare #(
  parameter int          CNT_W      = 16,
  parameter int unsigned WINDOW     = 10000,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             RO_A,
  input  logic             RO_B,
  output logic             RO_EN,
  output logic             BUSY,
  output logic             RESP_VALID,
  input  logic             RESP_ACK,
  output logic             RESP_BIT,
  output logic             TIE,
  output logic [CNT_W-1:0] COUNT_A,
  output logic [CNT_W-1:0] COUNT_B
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    COUNT   = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] timer_reg, timer_next;
  logic        clr_cnt, cnt_en, cmp_en;
  logic        resp_bit_reg, tie_reg;
  logic [1:0]  ro_in;

  assign ro_in = {RO_B, RO_A};

  // Channel 0 is oscillator A, channel 1 is oscillator B.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic             sync1_reg, sync2_reg, hist_reg;
    logic             rise;
    logic [CNT_W-1:0] cnt_reg;

    assign rise = sync2_reg & ~hist_reg;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        sync1_reg <= 1'b0;
        sync2_reg <= 1'b0;
        hist_reg  <= 1'b0;
      end else begin
        sync1_reg <= ro_in[gi];
        sync2_reg <= sync1_reg;
        hist_reg  <= sync2_reg;
      end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        cnt_reg <= '0;
      end else if (clr_cnt) begin
        cnt_reg <= '0;
      end else if (cnt_en && rise && (cnt_reg != {CNT_W{1'b1}})) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign COUNT_A = g_ch[0].cnt_reg;
  assign COUNT_B = g_ch[1].cnt_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= IDLE;
      timer_reg <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    clr_cnt    = 1'b0;
    cnt_en     = 1'b0;
    cmp_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (START) begin
          state_next = SETTLE;
          timer_next = 32'(SETTLE_CYC - 1);
          clr_cnt    = 1'b1;
        end
      end
      SETTLE: begin
        if (timer_reg == 32'd0) begin
          state_next = COUNT;
          timer_next = 32'(WINDOW - 1);
        end else begin
          timer_next = timer_reg - 32'd1;
        end
      end
      COUNT: begin
        cnt_en = 1'b1;
        if (timer_reg == 32'd0) begin
          state_next = COMPARE;
        end else begin
          timer_next = timer_reg - 32'd1;
        end
      end
      COMPARE: begin
        cmp_en     = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        if (RESP_ACK) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      resp_bit_reg <= 1'b0;
      tie_reg      <= 1'b0;
    end else if (cmp_en) begin
      resp_bit_reg <= (g_ch[0].cnt_reg > g_ch[1].cnt_reg);
      tie_reg      <= (g_ch[0].cnt_reg == g_ch[1].cnt_reg);
    end
  end

  assign RO_EN      = (state_reg == SETTLE) || (state_reg == COUNT);
  assign BUSY       = (state_reg != IDLE);
  assign RESP_VALID = (state_reg == DONE);
  assign RESP_BIT   = resp_bit_reg;
  assign TIE        = tie_reg;

endmodule

// File: tb/tb_ro_pair_compare.sv
// Directed bench for ro_pair_compare: timed RO waveforms, hand-computed counts,
// handshake, reset-mid-run and saturation runs.
`timescale 1ns/100ps
module tb_ro_pair_compare;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ro_a = 1'b0;
  logic ro_b = 1'b0;

  // RO waveforms derived from a 0.5 ns tick so equal periods stay phase-locked.
  longint ticks = 0;
  int     half_a = 100;
  int     half_b = 125;
  bit     man_mode = 1'b0;
  logic   man_a = 1'b0;

  int total = 0;
  int bad = 0;

  logic        start_m = 1'b0, ack_m = 1'b0;
  logic        en_m, busy_m, vld_m, bit_m, tie_m;
  logic [15:0] ca_m, cb_m;

  logic        start_s = 1'b0, ack_s = 1'b0;
  logic        en_6, busy_6, vld_6, bit_6, tie_6;
  logic [5:0]  ca_6, cb_6;
  logic        en_5, busy_5, vld_5, bit_5, tie_5;
  logic [4:0]  ca_5, cb_5;

  ro_pair_compare #(.CNT_W(16), .WINDOW(1000), .SETTLE_CYC(4)) u_main (
    .CLK(clk), .RST_N(rst_n), .START(start_m), .RO_A(ro_a), .RO_B(ro_b),
    .RO_EN(en_m), .BUSY(busy_m), .RESP_VALID(vld_m), .RESP_ACK(ack_m),
    .RESP_BIT(bit_m), .TIE(tie_m), .COUNT_A(ca_m), .COUNT_B(cb_m)
  );

  ro_pair_compare #(.CNT_W(6), .WINDOW(1000), .SETTLE_CYC(4)) u_sat6 (
    .CLK(clk), .RST_N(rst_n), .START(start_s), .RO_A(ro_a), .RO_B(ro_b),
    .RO_EN(en_6), .BUSY(busy_6), .RESP_VALID(vld_6), .RESP_ACK(ack_s),
    .RESP_BIT(bit_6), .TIE(tie_6), .COUNT_A(ca_6), .COUNT_B(cb_6)
  );

  ro_pair_compare #(.CNT_W(5), .WINDOW(1000), .SETTLE_CYC(4)) u_sat5 (
    .CLK(clk), .RST_N(rst_n), .START(start_s), .RO_A(ro_a), .RO_B(ro_b),
    .RO_EN(en_5), .BUSY(busy_5), .RESP_VALID(vld_5), .RESP_ACK(ack_s),
    .RESP_BIT(bit_5), .TIE(tie_5), .COUNT_A(ca_5), .COUNT_B(cb_5)
  );

  // Clock rising edges at 7+10k ns never coincide with RO edges (multiples of 2.5 ns).
  initial begin
    #2;
    forever #5 clk = ~clk;
  end

  always #0.5 begin
    ticks++;
    ro_a = man_mode ? man_a : (((ticks / longint'(half_a)) % 2) == 1);
    ro_b = (((ticks / longint'(half_b)) % 2) == 1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic bit near(input int v, input int target);
    return (v >= target - 1) && (v <= target + 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // START at cycle 0; returns the cycle index at which RESP_VALID is seen.
  task automatic run_main(input bit raise_a_in_settle, output int cyc,
                          output logic en_first, output logic en_cmp);
    tick();
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    cyc = 1;
    en_first = en_m & busy_m;
    en_cmp = 1'b1;
    if (raise_a_in_settle) man_a = 1'b1;
    while (!vld_m && cyc < 3000) begin
      tick();
      cyc++;
      if (cyc == 1005) en_cmp = en_m;
    end
    $display("run: cyc=%0d a=%0d b=%0d bit=%0b tie=%0b", cyc, ca_m, cb_m, bit_m, tie_m);
  endtask

  task automatic ack_main();
    ack_m = 1'b1;
    tick();
    ack_m = 1'b0;
  endtask

  initial begin
    int   cyc;
    logic en1, encmp;
    logic [15:0] sa, sb;
    logic sbit, stie;
    bit   stable_ok;

    repeat (3) tick();
    check("rst_state", {en_m, busy_m, vld_m, bit_m, tie_m, ca_m, cb_m}, 64'd0);
    rst_n = 1'b1;
    tick();

    // A toggles in IDLE, then rises inside SETTLE and stays high: count stays 0.
    man_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      man_a = ~man_a;
      tick();
      tick();
    end
    check("idle_edges_ignored", ca_m, 16'd0);
    check("idle_ro_en", en_m, 1'b0);
    man_a = 1'b0;
    repeat (4) tick();
    run_main(1'b1, cyc, en1, encmp);
    check("gate_cyc", cyc, 1006);
    check("gate_en_settle", en1, 1'b1);
    check("settle_edge_ignored", ca_m, 16'd0);
    check("gate_b_near80", near(int'(cb_m), 80), 1'b1);
    check("gate_bit", bit_m, 1'b0);
    ack_main();
    man_mode = 1'b0;

    // Basic A>B.
    half_a = 100;
    half_b = 125;
    repeat (5) tick();
    run_main(1'b0, cyc, en1, encmp);
    check("ab_cyc", cyc, 1006);
    check("ab_en_compare", encmp, 1'b0);
    check("ab_en_done", en_m, 1'b0);
    check("ab_a_near100", near(int'(ca_m), 100), 1'b1);
    check("ab_b_near80", near(int'(cb_m), 80), 1'b1);
    check("ab_bit", bit_m, 1'b1);
    check("ab_tie", tie_m, 1'b0);

    // Handshake hold with a stray START in DONE.
    sa = ca_m; sb = cb_m; sbit = bit_m; stie = tie_m;
    stable_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      start_m = (i == 5);
      tick();
      if (!vld_m || en_m || ca_m !== sa || cb_m !== sb || bit_m !== sbit || tie_m !== stie)
        stable_ok = 1'b0;
    end
    start_m = 1'b0;
    check("hold_stable", stable_ok, 1'b1);
    ack_main();
    check("ack_busy", busy_m, 1'b0);
    check("ack_valid", vld_m, 1'b0);
    repeat (30) tick();
    check("start_not_queued", busy_m, 1'b0);
    check("idle_keeps_a", ca_m, sa);

    // B>A.
    half_a = 125;
    half_b = 100;
    repeat (3) tick();
    run_main(1'b0, cyc, en1, encmp);
    check("ba_a_near80", near(int'(ca_m), 80), 1'b1);
    check("ba_b_near100", near(int'(cb_m), 100), 1'b1);
    check("ba_bit", bit_m, 1'b0);
    check("ba_tie", tie_m, 1'b0);
    ack_main();

    // Identical phase-locked drives.
    half_a = 100;
    half_b = 100;
    repeat (3) tick();
    run_main(1'b0, cyc, en1, encmp);
    check("tie_a_near100", near(int'(ca_m), 100), 1'b1);
    check("tie_equal", ca_m == cb_m, 1'b1);
    check("tie_bit", bit_m, 1'b0);
    check("tie_flag", tie_m, 1'b1);
    ack_main();

    // Reset at COUNT cycle 500 (cycle 504), asynchronously between edges.
    half_a = 100;
    half_b = 125;
    tick();
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    repeat (503) tick();
    check("mid_en", en_m, 1'b1);
    check("mid_a_counting", ca_m > 16'd40, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_outs", {en_m, busy_m, vld_m, bit_m, tie_m, ca_m, cb_m}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_main(1'b0, cyc, en1, encmp);
    check("post_rst_cyc", cyc, 1006);
    check("post_rst_a_near100", near(int'(ca_m), 100), 1'b1);
    check("post_rst_b_near80", near(int'(cb_m), 80), 1'b1);
    ack_main();

    // Saturation on narrow counters.
    half_a = 100;
    half_b = 200;
    tick();
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    cyc = 1;
    while (!(vld_6 && vld_5) && cyc < 3000) begin
      tick();
      cyc++;
    end
    $display("sat: cyc=%0d a6=%0d b6=%0d a5=%0d b5=%0d", cyc, ca_6, cb_6, ca_5, cb_5);
    check("sat_cyc", cyc, 1006);
    check("sat6_a", ca_6, 6'd63);
    check("sat6_b_near50", near(int'(cb_6), 50), 1'b1);
    check("sat6_bit", bit_6, 1'b1);
    check("sat5_a", ca_5, 5'd31);
    check("sat5_b", cb_5, 5'd31);
    check("sat5_tie", tie_5, 1'b1);
    check("sat5_bit", bit_5, 1'b0);
    ack_s = 1'b1;
    tick();
    ack_s = 1'b0;
    check("sat_idle", {busy_6, busy_5}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
